// File: rtl/hex_pkg.sv
// Shared definitions for the hex display scan controller.
package hex_pkg;
  localparam int         IDX_W     = 3;
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  typedef enum logic [1:0] {
    LOAD,
    SAMPLE,
    HOLD
  } scan_state_t;
endpackage

// File: rtl/wr_arbiter2.sv
// Two-requester round-robin write arbiter. The grant is combinational and the ack is registered.
// A requester whose ack is high is not eligible, so holding req through the ack cycle gives no second write.
module wr_arbiter2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic [1:0] ack
);
  logic       ptr;
  logic [1:0] elig;

  always_comb begin
    elig  = req & ~ack;
    grant = 2'b00;
    if (elig == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    else               grant = elig;
  end

  // The pointer only moves on contention; it always hands priority to the side that just lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ack <= 2'b00;
      ptr <= 1'b0;
    end else begin
      ack <= grant;
      if (elig == 2'b11) ptr <= ~ptr;
    end
  end
endmodule

// File: rtl/hex_scan_controller.sv
// Scans a digit register file through one shared external hex decoder and latches per-display segments.
//   state  | meaning
//   LOAD   | drive digit[scan_idx] onto dec_in
//   SAMPLE | latch dec_seg (or blank) into the slice of scan_idx, arm hold timer
//   HOLD   | wait out the rest of the slot, then advance scan_idx
module hex_scan_controller
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int REFRESH_DIV = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [1:0]                wr_req,
  output logic [1:0]                wr_ack,
  input  logic [2:0]                wr_addr0,
  input  logic [2:0]                wr_addr1,
  input  logic [3:0]                wr_data0,
  input  logic [3:0]                wr_data1,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  output logic [3:0]                dec_in,
  input  logic [6:0]                dec_seg,
  output logic [7*NUM_DIGITS-1:0]   seg_out,
  output logic [IDX_W-1:0]          scan_idx,
  output logic                      frame_done
);
  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(REFRESH_DIV - 3);

  scan_state_t               state, state_nxt;
  logic [CNT_W-1:0]          hold_cnt;
  logic                      ld_dec, ld_seg, advance;
  logic [1:0]                grant;
  logic [2:0]                wr_addr;
  logic [3:0]                wr_data;
  logic                      wr_hit;
  logic [3:0]                digit [1 << IDX_W];
  logic [7*NUM_DIGITS-1:0]   seg_q;

  wr_arbiter2 u_arb (
    .clock  (clock),
    .resetn (resetn),
    .req    (wr_req),
    .grant  (grant),
    .ack    (wr_ack)
  );

  assign wr_addr = grant[1] ? wr_addr1 : wr_addr0;
  assign wr_data = grant[1] ? wr_data1 : wr_data0;
  // Out-of-range addresses are still acked by the arbiter; only the store is suppressed.
  assign wr_hit  = (|grant) && ({1'b0, wr_addr} < 4'(NUM_DIGITS));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < (1 << IDX_W); i++) digit[i] <= 4'h0;
    end else if (wr_hit) begin
      digit[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= LOAD;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = SAMPLE;
      SAMPLE:  state_nxt = HOLD;
      HOLD:    if (hold_cnt == '0) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    ld_dec  = (state == LOAD);
    ld_seg  = (state == SAMPLE);
    advance = (state == HOLD) && (hold_cnt == '0);
  end

  // Down-counter covers REFRESH_DIV-2 HOLD cycles, terminating at zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                              hold_cnt <= '0;
    else if (ld_seg)                          hold_cnt <= HOLD_TC;
    else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dec_in     <= 4'h0;
      seg_q      <= '1;
      scan_idx   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (ld_dec) dec_in <= digit[scan_idx];
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (ld_seg && scan_idx == IDX_W'(i))
          seg_q[7*i +: 7] <= blank_mask[i] ? BLANK_SEG : dec_seg;
      end
      if (advance) begin
        if (scan_idx == LAST_IDX) begin
          scan_idx   <= '0;
          frame_done <= 1'b1;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end
  end

  assign seg_out = seg_q;
endmodule
